// File: rtl/id_stage.sv
// RV32I decode stage: turns one fetched instruction into an ALU operand/select
// bundle plus memory, branch and writeback control, behind one valid/ready register.
module id_stage #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [WORD_SIZE-1:0] in_pc,
    input  logic                 flush,
    output logic [4:0]           rs1_addr,
    output logic [4:0]           rs2_addr,
    input  logic [WORD_SIZE-1:0] rs1_data,
    input  logic [WORD_SIZE-1:0] rs2_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_arg_a,
    output logic [WORD_SIZE-1:0] out_arg_b,
    output logic [3:0]           out_alu_sel,
    output logic [WORD_SIZE-1:0] out_imm,
    output logic [WORD_SIZE-1:0] out_store_data,
    output logic [WORD_SIZE-1:0] out_pc,
    output logic [4:0]           out_rd,
    output logic                 out_reg_write,
    output logic                 out_mem_read,
    output logic                 out_mem_write,
    output logic                 out_branch,
    output logic [2:0]           out_funct3,
    output logic                 out_jump,
    output logic                 out_illegal
);

    typedef enum logic [3:0] {
        ALU_NONE = 4'h0,
        ALU_ADD  = 4'h1,
        ALU_SUB  = 4'h2,
        ALU_XOR  = 4'h3,
        ALU_OR   = 4'h4,
        ALU_AND  = 4'h5,
        ALU_SLL  = 4'h6,
        ALU_SRL  = 4'h7,
        ALU_SRA  = 4'h8,
        ALU_SLT  = 4'h9,
        ALU_SLTU = 4'hA,
        ALU_LUI  = 4'hB
    } alu_sel_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign rd       = in_instr[11:7];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    // x0 reads as zero no matter what the register file returns
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    assign rs1_val = (rs1_addr == 5'd0) ? 32'd0 : rs1_data;
    assign rs2_val = (rs2_addr == 5'd0) ? 32'd0 : rs2_data;

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};

    // funct3 mapping shared by OP and OP-IMM; SUB is patched in for OP only
    alu_sel_e arith_sel;
    always_comb begin
        arith_sel = ALU_ADD;
        case (funct3)
            3'b000:  arith_sel = ALU_ADD;
            3'b001:  arith_sel = ALU_SLL;
            3'b010:  arith_sel = ALU_SLT;
            3'b011:  arith_sel = ALU_SLTU;
            3'b100:  arith_sel = ALU_XOR;
            3'b101:  arith_sel = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            3'b110:  arith_sel = ALU_OR;
            default: arith_sel = ALU_AND;
        endcase
    end

    logic op_funct7_ok;
    logic op_imm_funct7_ok;

    assign op_funct7_ok = (funct7 == F7_BASE) ||
                          ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    assign op_imm_funct7_ok = (funct3 == 3'b001) ? (funct7 == F7_BASE) :
                              (funct3 == 3'b101) ? ((funct7 == F7_BASE) || (funct7 == F7_ALT)) :
                              1'b1;

    alu_sel_e    dec_sel;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [31:0] dec_imm;
    logic [31:0] dec_store;
    logic        dec_reg_write;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_branch;
    logic        dec_jump;
    logic        dec_illegal;

    always_comb begin
        dec_sel       = ALU_NONE;
        dec_a         = 32'd0;
        dec_b         = 32'd0;
        dec_imm       = 32'd0;
        dec_store     = 32'd0;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch    = 1'b0;
        dec_jump      = 1'b0;
        dec_illegal   = 1'b0;

        case (opcode)
            OPC_OP: begin
                dec_sel       = ((funct3 == 3'b000) && (funct7 == F7_ALT)) ? ALU_SUB : arith_sel;
                dec_a         = rs1_val;
                dec_b         = rs2_val;
                dec_reg_write = 1'b1;
                dec_illegal   = !op_funct7_ok;
            end
            OPC_OP_IMM: begin
                dec_sel       = arith_sel;
                dec_a         = rs1_val;
                dec_b         = imm_i;
                dec_imm       = imm_i;
                dec_reg_write = 1'b1;
                dec_illegal   = !op_imm_funct7_ok;
            end
            OPC_LOAD: begin
                dec_sel       = ALU_ADD;
                dec_a         = rs1_val;
                dec_b         = imm_i;
                dec_imm       = imm_i;
                dec_mem_read  = 1'b1;
                dec_reg_write = 1'b1;
            end
            OPC_STORE: begin
                dec_sel       = ALU_ADD;
                dec_a         = rs1_val;
                dec_b         = imm_s;
                dec_imm       = imm_s;
                dec_store     = rs2_val;
                dec_mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                // compare ops: equality via SUB, ordering via SLT/SLTU
                case (funct3[2:1])
                    2'b00:   dec_sel = ALU_SUB;
                    2'b10:   dec_sel = ALU_SLT;
                    2'b11:   dec_sel = ALU_SLTU;
                    default: dec_sel = ALU_NONE;
                endcase
                dec_a       = rs1_val;
                dec_b       = rs2_val;
                dec_imm     = imm_b;
                dec_branch  = 1'b1;
                dec_illegal = (funct3[2:1] == 2'b01);
            end
            OPC_LUI: begin
                dec_sel       = ALU_LUI;
                dec_b         = imm_u;
                dec_imm       = imm_u;
                dec_reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec_sel       = ALU_ADD;
                dec_a         = in_pc;
                dec_b         = imm_u;
                dec_imm       = imm_u;
                dec_reg_write = 1'b1;
            end
            OPC_JAL: begin
                dec_sel       = ALU_ADD;
                dec_a         = in_pc;
                dec_b         = 32'd4;
                dec_imm       = imm_j;
                dec_jump      = 1'b1;
                dec_reg_write = 1'b1;
            end
            OPC_JALR: begin
                dec_sel       = ALU_ADD;
                dec_a         = in_pc;
                dec_b         = 32'd4;
                dec_imm       = imm_i;
                dec_jump      = 1'b1;
                dec_reg_write = 1'b1;
                dec_illegal   = (funct3 != 3'b000);
            end
            default: dec_illegal = 1'b1;
        endcase

        // an illegal bundle still flows downstream but must not cause side effects
        if (dec_illegal) begin
            dec_sel       = ALU_NONE;
            dec_reg_write = 1'b0;
            dec_mem_read  = 1'b0;
            dec_mem_write = 1'b0;
            dec_branch    = 1'b0;
            dec_jump      = 1'b0;
        end
        if (rd == 5'd0) begin
            dec_reg_write = 1'b0;
        end
    end

    logic capture;

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready;

    // flush beats capture; data registers keep stale contents when killed
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_arg_a      <= '0;
            out_arg_b      <= '0;
            out_alu_sel    <= 4'd0;
            out_imm        <= '0;
            out_store_data <= '0;
            out_pc         <= '0;
            out_rd         <= 5'd0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_branch     <= 1'b0;
            out_funct3     <= 3'd0;
            out_jump       <= 1'b0;
            out_illegal    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid      <= 1'b1;
            out_arg_a      <= dec_a;
            out_arg_b      <= dec_b;
            out_alu_sel    <= dec_sel;
            out_imm        <= dec_imm;
            out_store_data <= dec_store;
            out_pc         <= in_pc;
            out_rd         <= rd;
            out_reg_write  <= dec_reg_write;
            out_mem_read   <= dec_mem_read;
            out_mem_write  <= dec_mem_write;
            out_branch     <= dec_branch;
            out_funct3     <= funct3;
            out_jump       <= dec_jump;
            out_illegal    <= dec_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed RV32I cases with literal expectations, then random
// traffic checked every cycle against an instruction-level reference model.
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_arg_a;
    logic [31:0] out_arg_b;
    logic [3:0]  out_alu_sel;
    logic [31:0] out_imm;
    logic [31:0] out_store_data;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_branch;
    logic [2:0]  out_funct3;
    logic        out_jump;
    logic        out_illegal;

    int compared;
    int mismatched;

    id_stage #(.WORD_SIZE(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_arg_a(out_arg_a),
        .out_arg_b(out_arg_b), .out_alu_sel(out_alu_sel), .out_imm(out_imm),
        .out_store_data(out_store_data), .out_pc(out_pc), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_branch(out_branch), .out_funct3(out_funct3),
        .out_jump(out_jump), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b, imm, store, pc;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        rw, mr, mw, br, jp, ill;
        bit          care_ab, care_imm, care_store;
    } bundle_t;

    // Instruction-level meaning of each RV32I encoding, written from the ISA rules
    function automatic bundle_t model_decode(logic [31:0] ins, logic [31:0] pc,
                                             logic [31:0] d1, logic [31:0] d2);
        bundle_t     e;
        logic [3:0]  tab [0:7];
        logic [31:0] op1, op2, ii, is, ib, iu, ij;
        logic [2:0]  f3;
        logic [6:0]  f7;
        bit          legal;
        tab = '{4'h1, 4'h6, 4'h9, 4'hA, 4'h3, 4'h7, 4'h4, 4'h5};
        f3  = ins[14:12];
        f7  = ins[31:25];
        op1 = (ins[19:15] == 0) ? 32'd0 : d1;
        op2 = (ins[24:20] == 0) ? 32'd0 : d2;
        ii  = {{20{ins[31]}}, ins[31:20]};
        is  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        iu  = {ins[31:12], 12'd0};
        ij  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        e = '{a: 0, b: 0, imm: 0, store: 0, pc: pc, sel: 0, rd: ins[11:7], f3: f3,
              rw: 0, mr: 0, mw: 0, br: 0, jp: 0, ill: 0,
              care_ab: 1, care_imm: 0, care_store: 0};
        legal = 1;
        case (ins[6:0])
            7'h33: begin
                legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                e.sel = tab[f3] + ((f7 == 7'h20) ? 4'd1 : 4'd0);
                e.a = op1; e.b = op2; e.rw = 1;
            end
            7'h13: begin
                legal = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
                e.sel = tab[f3] + ((f3 == 5 && f7 == 7'h20) ? 4'd1 : 4'd0);
                e.a = op1; e.b = ii; e.imm = ii; e.care_imm = 1; e.rw = 1;
            end
            7'h03: begin
                e.sel = 1; e.a = op1; e.b = ii; e.imm = ii; e.care_imm = 1; e.mr = 1; e.rw = 1;
            end
            7'h23: begin
                e.sel = 1; e.a = op1; e.b = is; e.imm = is; e.care_imm = 1; e.mw = 1;
                e.store = op2; e.care_store = 1;
            end
            7'h63: begin
                legal = (f3[2:1] != 2'b01);
                e.sel = (f3 < 2) ? 4'd2 : (f3 < 6) ? 4'd9 : 4'd10;
                e.a = op1; e.b = op2; e.imm = ib; e.care_imm = 1; e.br = 1;
            end
            7'h37: begin e.sel = 11; e.b = iu; e.imm = iu; e.care_imm = 1; e.rw = 1; end
            7'h17: begin e.sel = 1; e.a = pc; e.b = iu; e.imm = iu; e.care_imm = 1; e.rw = 1; end
            7'h6F: begin e.sel = 1; e.a = pc; e.b = 4; e.imm = ij; e.care_imm = 1; e.jp = 1; e.rw = 1; end
            7'h67: begin
                legal = (f3 == 0);
                e.sel = 1; e.a = pc; e.b = 4; e.imm = ii; e.care_imm = 1; e.jp = 1; e.rw = 1;
            end
            default: legal = 0;
        endcase
        if (!legal) begin
            e.ill = 1; e.sel = 0; e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.jp = 0;
            e.care_ab = 0; e.care_imm = 0; e.care_store = 0;
        end
        if (e.rd == 0) e.rw = 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [31:0] ins,
                                 input logic [31:0] pc, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic rdy, input logic fl);
        @(negedge clk);
        #1;
        rst = r; in_valid = v; in_instr = ins; in_pc = pc;
        rs1_data = d1; rs2_data = d2; out_ready = rdy; flush = fl;
    endtask

    // reference state, advanced from the bench's own inputs only
    bit      m_ok;
    bit      m_valid;
    bit      m_zero;
    bundle_t m_exp;

    always @(posedge clk) begin
        if (rst) begin
            m_ok    <= 1;
            m_valid <= 0;
            m_zero  <= 1;
        end else if (flush) begin
            m_valid <= 0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid <= 1;
            m_zero  <= 0;
            m_exp   <= model_decode(in_instr, in_pc, rs1_data, rs2_data);
        end else if (out_ready) begin
            m_valid <= 0;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            checkOutput("in_ready", in_ready, !m_valid || out_ready);
            checkOutput("rs1_addr", rs1_addr, in_instr[19:15]);
            checkOutput("rs2_addr", rs2_addr, in_instr[24:20]);
            checkOutput("out_valid", out_valid, m_valid);
            if (m_zero) begin
                checkOutput("zero_a", out_arg_a, 0);
                checkOutput("zero_b", out_arg_b, 0);
                checkOutput("zero_ctl", {out_alu_sel, out_rd, out_funct3, out_reg_write,
                            out_mem_read, out_mem_write, out_branch, out_jump, out_illegal}, 0);
                checkOutput("zero_imm", out_imm | out_store_data | out_pc, 0);
            end else if (m_valid) begin
                checkOutput("alu_sel", out_alu_sel, m_exp.sel);
                checkOutput("illegal", out_illegal, m_exp.ill);
                checkOutput("ctl", {out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump},
                            {m_exp.rw, m_exp.mr, m_exp.mw, m_exp.br, m_exp.jp});
                checkOutput("rd", out_rd, m_exp.rd);
                checkOutput("funct3", out_funct3, m_exp.f3);
                checkOutput("pc", out_pc, m_exp.pc);
                if (m_exp.care_ab) begin
                    checkOutput("arg_a", out_arg_a, m_exp.a);
                    checkOutput("arg_b", out_arg_b, m_exp.b);
                end
                if (m_exp.care_imm) checkOutput("imm", out_imm, m_exp.imm);
                if (m_exp.care_store) checkOutput("store_data", out_store_data, m_exp.store);
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [0:9];
        logic [31:0] r;
        int          k;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h33};
        r = $urandom;
        k = $urandom_range(0, 10);
        if (k == 10) return r;
        r[6:0] = ops[k];
        if ((ops[k] == 7'h33 || ops[k] == 7'h13) && ($urandom_range(0, 3) != 0))
            r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        if ($urandom_range(0, 7) == 0) r[19:15] = 0;
        if ($urandom_range(0, 7) == 0) r[11:7] = 0;
        return r;
    endfunction

    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_ADDI = 32'hFFF00093;
    localparam logic [31:0] I_SW   = 32'h0020A223;
    localparam logic [31:0] I_BLT  = 32'h0020C463;

    initial begin
        compared = 0; mismatched = 0;
        rst = 1; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0;
        rs1_data = 0; rs2_data = 0; out_ready = 0;

        applyStimulus(1, 1, I_SUB, 32'h40, 7, 5, 1, 0);
        applyStimulus(1, 1, I_SUB, 32'h40, 7, 5, 1, 0);
        @(posedge clk); #2;
        checkOutput("lit_reset_valid", out_valid, 0);
        checkOutput("lit_reset_sel", out_alu_sel, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        checkOutput("lit_ready_after_reset", in_ready, 1);

        applyStimulus(0, 1, I_SUB, 32'h100, 7, 5, 1, 0);
        @(posedge clk); #2;
        checkOutput("lit_sub_valid", out_valid, 1);
        checkOutput("lit_sub_sel", out_alu_sel, 2);
        checkOutput("lit_sub_a", out_arg_a, 7);
        checkOutput("lit_sub_b", out_arg_b, 5);
        checkOutput("lit_sub_rd", out_rd, 3);
        checkOutput("lit_sub_rw", out_reg_write, 1);

        applyStimulus(0, 1, I_ADDI, 32'h104, 32'h1234, 9, 1, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, I_SW, 32'h108, 32'h20, 32'h30, 0, 0);
            @(posedge clk); #2;
            checkOutput("lit_stall_ready", in_ready, 0);
            checkOutput("lit_stall_sel", out_alu_sel, 1);
            checkOutput("lit_stall_a", out_arg_a, 0);
            checkOutput("lit_stall_b", out_arg_b, 32'hFFFFFFFF);
        end

        applyStimulus(0, 1, I_SW, 32'h108, 32'h1000, 32'hCAFE, 1, 0);
        @(posedge clk); #2;
        checkOutput("lit_sw_valid", out_valid, 1);
        checkOutput("lit_sw_sel", out_alu_sel, 1);
        checkOutput("lit_sw_b", out_arg_b, 4);
        checkOutput("lit_sw_mw", out_mem_write, 1);
        checkOutput("lit_sw_rw", out_reg_write, 0);
        checkOutput("lit_sw_store", out_store_data, 32'hCAFE);

        applyStimulus(0, 1, I_BLT, 32'h10C, 3, 9, 1, 0);
        @(posedge clk); #2;
        checkOutput("lit_blt_sel", out_alu_sel, 9);
        checkOutput("lit_blt_branch", out_branch, 1);
        checkOutput("lit_blt_f3", out_funct3, 3'b100);
        checkOutput("lit_blt_imm", out_imm, 8);

        applyStimulus(0, 1, 32'h00100093, 32'h110, 0, 0, 0, 1);
        @(posedge clk); #2;
        checkOutput("lit_flush_valid", out_valid, 0);
        applyStimulus(0, 0, 32'h00100093, 32'h110, 0, 0, 1, 0);
        @(posedge clk); #2;
        checkOutput("lit_flush_dropped", out_valid, 0);

        applyStimulus(0, 1, 32'h0000007F, 32'h114, 1, 2, 1, 0);
        @(posedge clk); #2;
        checkOutput("lit_ill_op_flag", out_illegal, 1);
        checkOutput("lit_ill_op_sel", out_alu_sel, 0);
        checkOutput("lit_ill_op_we", {out_reg_write, out_mem_write, out_mem_read}, 0);
        applyStimulus(0, 1, 32'h022081B3, 32'h118, 1, 2, 1, 0);
        @(posedge clk); #2;
        checkOutput("lit_ill_f7_flag", out_illegal, 1);
        checkOutput("lit_ill_f7_sel", out_alu_sel, 0);
        checkOutput("lit_ill_f7_rw", out_reg_write, 0);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                          rand_instr(), {$urandom, 2'b00} & 32'hFFFF_FFFC, $urandom, $urandom,
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage that produces the ALU's operand/select interface: decodes one RV32I instruction per handshake, reads the register file and drives arg_a, arg_b and alu_sel.
- Sits between fetch and execute with a single valid/ready pipeline register.
- Also emits register/memory/branch control for downstream stages.
- alu_sel encoding (fixed): ADD=1, SUB=2, XOR=3, OR=4, AND=5, SLL=6, SRL=7, SRA=8, SLT=9, SLTU=A, LUI=B, 0=none.

Parameters:
- WORD_SIZE, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address
- flush  in  1  kill held and incoming instruction
- rs1_addr  out  5  regfile read address = in_instr[19:15], combinational
- rs2_addr  out  5  regfile read address = in_instr[24:20], combinational
- rs1_data  in  32  regfile read data, same cycle
- rs2_data  in  32  regfile read data, same cycle
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- out_arg_a  out  32  ALU operand A
- out_arg_b  out  32  ALU operand B
- out_alu_sel  out  4  ALU operation
- out_imm  out  32  sign-extended immediate
- out_store_data  out  32  rs2 value for stores
- out_pc  out  32  PC of the decoded instruction
- out_rd  out  5  destination register
- out_reg_write  out  1  write rd; forced 0 when rd=0
- out_mem_read  out  1  load
- out_mem_write  out  1  store
- out_branch  out  1  conditional branch; condition in out_funct3
- out_funct3  out  3  instr[14:12]
- out_jump  out  1  JAL/JALR
- out_illegal  out  1  unrecognised encoding

Behaviour:
- Reset: out_valid=0 and every out_* register=0. in_ready=1 in the cycle after reset.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Capture when in_valid && in_ready. Latency is 1 cycle: the bundle appears the next cycle with out_valid=1.
  - The bundle is held stable while out_valid && !out_ready.
  - On accept (out_ready) with no new capture, out_valid goes to 0.
  - Back-to-back accept+capture gives full throughput.
- Flush: has priority. At the next edge out_valid=0 and the incoming instruction is dropped, even if in_valid && in_ready. Data registers may hold stale values. rst overrides flush.
- Register reads: rs1_data/rs2_data are sampled at the capture edge. Address 0 is forced to operand value 0 regardless of rs*_data.
- Immediates:
  - I: instr[31:20] sign-extended.
  - S: {31:25, 11:7}.
  - B: {31, 7, 30:25, 11:8, 0}.
  - U: {31:12, 12'b0}.
  - J: {31, 19:12, 20, 30:21, 0}.
- Decode by opcode:
  - OP 0110011: a=rs1, b=rs2. funct3 000 gives ADD, or SUB if funct7=0100000. 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 gives SRL, or SRA if funct7=0100000; 110 OR; 111 AND. funct7 must be 0000000, or 0100000 only for funct3 000/101; otherwise illegal. reg_write=1.
  - OP-IMM 0010011: a=rs1, b=imm_I, same mapping but 000 is always ADD. Shifts use funct7 as above (SRAI 0100000); other funct7 on shifts is illegal. reg_write=1.
  - LOAD 0000011: ADD, a=rs1, b=imm_I, mem_read=1, reg_write=1.
  - STORE 0100011: ADD, a=rs1, b=imm_S, mem_write=1, store_data=rs2.
  - BRANCH 1100011: a=rs1, b=rs2. BEQ/BNE use SUB; BLT/BGE use SLT; BLTU/BGEU use SLTU. funct3 010/011 is illegal. branch=1, imm=imm_B.
  - LUI 0110111: LUI, a=0, b=imm_U, reg_write=1.
  - AUIPC 0010111: ADD, a=pc, b=imm_U, reg_write=1.
  - JAL 1101111: ADD, a=pc, b=4, imm=imm_J, jump=1, reg_write=1.
  - JALR 1100111: ADD, a=pc, b=4, imm=imm_I, jump=1, reg_write=1. funct3≠000 is illegal.
  - Any other opcode is illegal.
- Illegal instructions: out_illegal=1, alu_sel=0, and reg_write, mem_*, branch and jump all 0. The bundle is still valid and handshaken.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, all outputs 0; after release in_ready=1.
- Capture `sub x3,x1,x2` (0x402081B3) with rs1_data=7, rs2_data=5 -> next cycle out_valid=1, sel=2, a=7, b=5, rd=3, reg_write=1.
- Stall: out_ready=0 for 3 cycles after an `addi x1,x0,-1` capture -> in_ready=0, bundle stable (sel=1, a=0, b=0xFFFFFFFF). Then out_ready=1 with a new in_valid -> next bundle the following cycle, no gap.
- Branch and store:
  - `blt` (0x0020C463) -> sel=9, branch=1, funct3=100, imm=8.
  - `sw x2,4(x1)` -> sel=1, b=4, mem_write=1, reg_write=0.
- Flush while holding a bundle with in_valid=1 -> out_valid=0 next cycle, the incoming instruction never appears.
- Illegal: opcode 0x7F, and OP with funct7=0x01 -> out_illegal=1, sel=0, no write enables.
